// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: runs one register-to-register ALU operation at a time.
// Flow: accept request -> read register file -> wait out the ALU latency -> write back.
// Optional build macro ALU_OP_SEQUENCER_R0_ZERO_EN: register 0 reads as zero and
// writes to it are dropped, while the response and op counter still update.
module alu_op_sequencer #(
  parameter int unsigned ALU_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [3:0]  alu_opcode,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  input  logic [31:0] alu_result,
  output logic        resp_valid,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  op_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [3:0]  wait_cnt;
  logic [4:0]  resp_rd_q;
  logic [31:0] opnd1, opnd2;
  logic        wb_en;

`ifdef ALU_OP_SEQUENCER_R0_ZERO_EN
  // Register 0 is hardwired zero: mask reads, suppress writes.
  assign opnd1 = (rs1_q == 5'd0) ? 32'h0 : rf_rdata1;
  assign opnd2 = (rs2_q == 5'd0) ? 32'h0 : rf_rdata2;
  assign wb_en = (rd_q != 5'd0);
`else
  // Register 0 behaves like any other register.
  assign opnd1 = rf_rdata1;
  assign opnd2 = rf_rdata2;
  assign wb_en = 1'b1;
`endif

  // Read and write ports always point at the latched indices.
  assign rf_raddr1 = rs1_q;
  assign rf_raddr2 = rs2_q;
  assign rf_waddr  = rd_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; EXEC exits once the last latency cycle is reached.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    if (wait_cnt <= 4'd1) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational outputs; the write port only carries data during WB.
  always_comb begin
    req_ready  = 1'b0;
    rf_we      = 1'b0;
    rf_wdata   = 32'h0;
    resp_valid = 1'b0;
    resp_rd    = resp_rd_q;
    case (state)
      IDLE: req_ready = 1'b1;
      WB: begin
        rf_we      = wb_en;
        rf_wdata   = alu_result;
        resp_valid = 1'b1;
        resp_rd    = rd_q;
      end
      default: ;
    endcase
  end

  // Capture the request fields on acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q  <= 4'd0;
      rd_q  <= 5'd0;
      rs1_q <= 5'd0;
      rs2_q <= 5'd0;
    end else if (state == IDLE && req_valid) begin
      op_q  <= req_op;
      rd_q  <= req_rd;
      rs1_q <= req_rs1;
      rs2_q <= req_rs2;
    end
  end

  // Present operands to the ALU in READ and hold them until the next READ.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_opcode <= 4'd0;
      alu_in1    <= 32'h0;
      alu_in2    <= 32'h0;
    end else if (state == READ) begin
      alu_opcode <= op_q;
      alu_in1    <= opnd1;
      alu_in2    <= opnd2;
    end
  end

  // Latency counter: loaded in READ, counts down through EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n)              wait_cnt <= 4'd0;
    else if (state == READ)  wait_cnt <= 4'(ALU_LAT);
    else if (state == EXEC)  wait_cnt <= wait_cnt - 4'd1;
  end

  // Response registers and completion counter update on write-back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_data <= 32'h0;
      resp_rd_q <= 5'd0;
      op_count  <= 16'd0;
    end else if (state == WB) begin
      resp_data <= alu_result;
      resp_rd_q <= rd_q;
      op_count  <= op_count + 16'd1;
    end
  end

endmodule
